// File: rtl/vip_mem_pkg.sv
// -----------------------------------------------------------------------------
// vip_mem_pkg
//   Shared types for the VIP memory model and its front-end arbiter.
//   vip_mem_cfg_t        : memory geometry (address width, data bytes per word)
//   vip_mem_x_severity_t : reaction to writes carrying X/Z on enabled bytes
// -----------------------------------------------------------------------------
package vip_mem_pkg;

    typedef struct packed {
        int unsigned ADDR_WIDTH_P;
        int unsigned DATA_BYTES_P;
    } vip_mem_cfg_t;

    typedef enum logic [1:0] {
        VIP_MEM_X_WR_IGNORE_E,
        VIP_MEM_X_WR_WARNING_E,
        VIP_MEM_X_WR_FATAL_E
    } vip_mem_x_severity_t;

endpackage

// File: rtl/vip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vip_mem_arbiter
//   Round-robin arbiter sharing one memory port between NR_OF_REQ_P requesters.
//   The granted request is registered onto mem_*; read requester IDs are kept
//   in an in-order FIFO so read data can be routed back to its originator.
//   Writes with X/Z on enabled bytes are handled according to X_SEVERITY_P.
//
// Ports (requester i occupies slice i of each flattened vector):
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/write/addr/wdata/wstrb  requester inputs
//   req_ready                    one-hot acceptance (combinational)
//   rsp_valid, rsp_rdata         read response, one cycle, per requester
//   mem_valid/write/addr/wdata/wstrb  registered memory request
//   mem_ready                    memory accepts the registered request
//   mem_rvalid, mem_rdata        in-order read response from memory
//   outstanding                  reads accepted but not yet answered
//   x_wr_count                   saturating count of flagged X writes
//   rsp_err                      sticky: mem_rvalid with no read outstanding
// -----------------------------------------------------------------------------
module vip_mem_arbiter
    import vip_mem_pkg::*;
#(
    parameter vip_mem_cfg_t        MEM_CFG_P         = '{ADDR_WIDTH_P: 16, DATA_BYTES_P: 4},
    parameter int unsigned         NR_OF_REQ_P       = 4,
    parameter int unsigned         MAX_OUTSTANDING_P = 4,
    parameter vip_mem_x_severity_t X_SEVERITY_P      = VIP_MEM_X_WR_WARNING_E
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic [NR_OF_REQ_P-1:0]                                  req_valid,
    output logic [NR_OF_REQ_P-1:0]                                  req_ready,
    input  logic [NR_OF_REQ_P-1:0]                                  req_write,
    input  logic [NR_OF_REQ_P*MEM_CFG_P.ADDR_WIDTH_P-1:0]           req_addr,
    input  logic [NR_OF_REQ_P*MEM_CFG_P.DATA_BYTES_P*8-1:0]         req_wdata,
    input  logic [NR_OF_REQ_P*MEM_CFG_P.DATA_BYTES_P-1:0]           req_wstrb,
    output logic [NR_OF_REQ_P-1:0]                                  rsp_valid,
    output logic [MEM_CFG_P.DATA_BYTES_P*8-1:0]                     rsp_rdata,
    output logic                                                    mem_valid,
    output logic                                                    mem_write,
    output logic [MEM_CFG_P.ADDR_WIDTH_P-1:0]                       mem_addr,
    output logic [MEM_CFG_P.DATA_BYTES_P*8-1:0]                     mem_wdata,
    output logic [MEM_CFG_P.DATA_BYTES_P-1:0]                       mem_wstrb,
    input  logic                                                    mem_ready,
    input  logic                                                    mem_rvalid,
    input  logic [MEM_CFG_P.DATA_BYTES_P*8-1:0]                     mem_rdata,
    output logic [$clog2(MAX_OUTSTANDING_P):0]                      outstanding,
    output logic [15:0]                                             x_wr_count,
    output logic                                                    rsp_err
);

    localparam int unsigned N  = NR_OF_REQ_P;
    localparam int unsigned A  = MEM_CFG_P.ADDR_WIDTH_P;
    localparam int unsigned D  = MEM_CFG_P.DATA_BYTES_P;
    localparam int unsigned IW = $clog2(NR_OF_REQ_P);
    localparam int unsigned PW = $clog2(MAX_OUTSTANDING_P);
    localparam int unsigned CW = PW + 1;

    // Per-requester views of the flattened inputs
    logic [A-1:0]        addr_a  [N];
    logic [D-1:0][7:0]   wdata_a [N];
    logic [D-1:0]        wstrb_a [N];
    logic [N-1:0]        eligible;

    // Registered memory request
    logic                mem_valid_q, mem_write_q;
    logic [A-1:0]        mem_addr_q;
    logic [D-1:0][7:0]   mem_wdata_q;
    logic [D-1:0]        mem_wstrb_q;

    // Arbitration state and read ID FIFO
    logic [IW-1:0]       last_grant_q;
    logic [IW-1:0]       id_fifo_q [MAX_OUTSTANDING_P];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       cnt_q, cnt_d;

    // Response / status registers
    logic [N-1:0]        rsp_valid_q, rsp_valid_d;
    logic [D*8-1:0]      rsp_rdata_q;
    logic [15:0]         x_cnt_q;
    logic                rsp_err_q;

    // Combinational arbitration results
    logic                free, gnt_found, accept, push, pop, x_flag;
    logic [IW-1:0]       gnt_idx;
    int unsigned         cand;
    logic [D-1:0]        byte_x;

    for (genvar g = 0; g < N; g++) begin : g_req
        assign addr_a[g]   = req_addr[g*A +: A];
        assign wdata_a[g]  = req_wdata[g*D*8 +: D*8];
        assign wstrb_a[g]  = req_wstrb[g*D +: D];
        // Reads are held off once the ID FIFO is full; writes never are
        assign eligible[g] = req_valid[g] && (req_write[g] || (cnt_q < CW'(MAX_OUTSTANDING_P)));
    end

    assign free = !mem_valid_q || mem_ready;

    // Search starts just after the last grant and wraps around
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (int'(last_grant_q) + k) % N;
            if (!gnt_found && eligible[IW'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
    end

    assign accept = free && gnt_found && !rst;
    assign push   = accept && !req_write[gnt_idx];
    assign pop    = mem_rvalid && (cnt_q != '0);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Only enabled bytes are inspected for X/Z
    for (genvar b = 0; b < D; b++) begin : g_xbyte
        assign byte_x[b] = wstrb_a[gnt_idx][b] && $isunknown(wdata_a[gnt_idx][b]);
    end
    assign x_flag = accept && req_write[gnt_idx] && (|byte_x);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        if (pop) begin
            rsp_valid_d[id_fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            last_grant_q <= IW'(N - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            x_cnt_q      <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (free) begin
                mem_valid_q <= gnt_found;
                if (gnt_found) begin
                    mem_write_q <= req_write[gnt_idx];
                    mem_addr_q  <= addr_a[gnt_idx];
                    mem_wdata_q <= wdata_a[gnt_idx];
                    mem_wstrb_q <= wstrb_a[gnt_idx];
                end
            end
            if (accept) begin
                last_grant_q <= gnt_idx;
            end
            if (push) begin
                id_fifo_q[wr_ptr_q] <= gnt_idx;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                rsp_rdata_q <= mem_rdata;
            end
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            if (mem_rvalid && (cnt_q == '0)) begin
                rsp_err_q <= 1'b1;
            end
            if (x_flag) begin
                case (X_SEVERITY_P)
                    VIP_MEM_X_WR_WARNING_E: begin
                        $warning("vip_mem_arbiter: X write from requester %0d at address 0x%0h",
                                 gnt_idx, addr_a[gnt_idx]);
                        if (x_cnt_q != '1) begin
                            x_cnt_q <= x_cnt_q + 1'b1;
                        end
                    end
                    VIP_MEM_X_WR_FATAL_E: begin
                        $fatal(1, "vip_mem_arbiter: X write from requester %0d at address 0x%0h",
                               gnt_idx, addr_a[gnt_idx]);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_valid   = mem_valid_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign outstanding = cnt_q;
    assign x_wr_count  = x_cnt_q;
    assign rsp_err     = rsp_err_q;

endmodule
